// File: rtl/icache_if.sv
// Fetch-query and memory-refill signals of the instruction cache, bundled as one bus.
// The cache uses the slave view; the fetcher/memory environment uses the master view.
interface icache_if;
    logic        icache_query_en;
    logic [31:0] icache_query_pc;
    logic        icache_data_en;
    logic [31:0] icache_addr_comfirm;
    logic [31:0] icache_data;
    logic        mem_req_en;
    logic [31:0] mem_req_addr;
    logic        mem_data_en;
    logic [31:0] mem_data;

    modport slave (
        input  icache_query_en, icache_query_pc, mem_data_en, mem_data,
        output icache_data_en, icache_addr_comfirm, icache_data, mem_req_en, mem_req_addr
    );

    modport master (
        output icache_query_en, icache_query_pc, mem_data_en, mem_data,
        input  icache_data_en, icache_addr_comfirm, icache_data, mem_req_en, mem_req_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: one-cycle hits, word-by-word line refill on miss,
// and flush cancellation so a squashed fetch never receives a response.
module icache #(
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic rdy_in,
    input  logic flush_signal,
    icache_if.slave bus
);
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] CNT_ONE = OFFSET_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    logic [TAG_WIDTH-1:0] tag_mem  [LINES];
    logic [31:0]          data_mem [LINES*WORDS];
    logic [LINES-1:0]     valid_q;

    state_t                  state_q, state_d;
    logic [31:0]             pc_q, pc_d;
    logic [OFFSET_WIDTH-1:0] cnt_q, cnt_d;
    logic                    cancel_q, cancel_d;
    logic                    cooldown_q, cooldown_d;
    logic                    req_en_q, req_en_d;
    logic [31:0]             req_addr_q, req_addr_d;
    logic                    rsp_en_q, rsp_en_d;
    logic [31:0]             rsp_addr_q, rsp_addr_d;
    logic [31:0]             rsp_data_q, rsp_data_d;
    logic                    fill_we;

    logic [INDEX_WIDTH-1:0]  q_index, l_index;
    logic [OFFSET_WIDTH-1:0] q_offset, l_offset;
    logic [TAG_WIDTH-1:0]    q_tag, l_tag;
    logic                    hit, accept, take_word, last_word;

    assign q_index   = bus.icache_query_pc[OFFSET_WIDTH+INDEX_WIDTH+1:OFFSET_WIDTH+2];
    assign q_offset  = bus.icache_query_pc[OFFSET_WIDTH+1:2];
    assign q_tag     = bus.icache_query_pc[31:32-TAG_WIDTH];
    assign l_index   = pc_q[OFFSET_WIDTH+INDEX_WIDTH+1:OFFSET_WIDTH+2];
    assign l_offset  = pc_q[OFFSET_WIDTH+1:2];
    assign l_tag     = pc_q[31:32-TAG_WIDTH];

    assign hit       = valid_q[q_index] && (tag_mem[q_index] == q_tag);
    // The fetcher drops query_en one cycle late, so the cycle after a response is deaf.
    assign accept    = bus.icache_query_en && !cooldown_q && !flush_signal;
    assign take_word = req_en_q && bus.mem_data_en;
    assign last_word = &cnt_q;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            cnt_q      <= '0;
            cancel_q   <= 1'b0;
            cooldown_q <= 1'b0;
            req_en_q   <= 1'b0;
            req_addr_q <= '0;
            rsp_en_q   <= 1'b0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            cancel_q   <= cancel_d;
            cooldown_q <= cooldown_d;
            req_en_q   <= req_en_d;
            req_addr_q <= req_addr_d;
            rsp_en_q   <= rsp_en_d;
            rsp_addr_q <= rsp_addr_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            case (state_q)
                IDLE:    if (accept && !hit) state_d = REFILL;
                REFILL:  if (take_word && last_word) state_d = (cancel_q || flush_signal) ? IDLE : RESPOND;
                RESPOND: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        cancel_d   = cancel_q;
        cooldown_d = cooldown_q;
        req_en_d   = req_en_q;
        req_addr_d = req_addr_q;
        rsp_en_d   = rsp_en_q;
        rsp_addr_d = rsp_addr_q;
        rsp_data_d = rsp_data_q;
        fill_we    = 1'b0;
        if (rdy_in) begin
            rsp_en_d   = 1'b0;
            cooldown_d = 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        pc_d = bus.icache_query_pc;
                        if (hit) begin
                            rsp_en_d   = 1'b1;
                            rsp_addr_d = bus.icache_query_pc;
                            rsp_data_d = data_mem[{q_index, q_offset}];
                            cooldown_d = 1'b1;
                        end else begin
                            cnt_d      = '0;
                            cancel_d   = 1'b0;
                            req_en_d   = 1'b1;
                            req_addr_d = {bus.icache_query_pc[31:OFFSET_WIDTH+2], {OFFSET_WIDTH{1'b0}}, 2'b00};
                        end
                    end
                end
                REFILL: begin
                    cancel_d = cancel_q || flush_signal;
                    if (take_word) begin
                        fill_we  = 1'b1;
                        req_en_d = 1'b0;
                        cnt_d    = cnt_q + CNT_ONE;
                        if (last_word) cancel_d = 1'b0;
                    end else if (!req_en_q) begin
                        // One idle cycle between words, then ask for the next word of the line.
                        req_en_d   = 1'b1;
                        req_addr_d = {pc_q[31:OFFSET_WIDTH+2], cnt_q, 2'b00};
                    end
                end
                RESPOND: begin
                    cancel_d = 1'b0;
                    if (!flush_signal) begin
                        rsp_en_d   = 1'b1;
                        rsp_addr_d = pc_q;
                        rsp_data_d = data_mem[{l_index, l_offset}];
                        cooldown_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            valid_q <= '0;
        end else if (fill_we && last_word) begin
            valid_q[l_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_mem[{l_index, cnt_q}] <= bus.mem_data;
            if (last_word) tag_mem[l_index] <= l_tag;
        end
    end

    assign bus.icache_data_en      = rsp_en_q;
    assign bus.icache_addr_comfirm = rsp_addr_q;
    assign bus.icache_data         = rsp_data_q;
    assign bus.mem_req_en          = req_en_q;
    assign bus.mem_req_addr        = req_addr_q;
endmodule

// File: tb/tb_icache.sv
// Bench for icache: scripted scenarios plus random queries, checked against a line-level cache model
// and a latency-randomised memory responder.
module tb_icache;
    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    logic flush;

    always #5 clk = ~clk;

    icache_if bus();

    icache dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .rdy_in       (rdy),
        .flush_signal (flush),
        .bus          (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int nreq  = 0;
    int ndata = 0;
    int nresp = 0;
    int lat_mode = 1;
    logic [31:0] req_q[$];

    bit          m_valid [16];
    logic [23:0] m_tag   [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memval(input logic [31:0] a);
        if (a < 32'h10) return 32'h11 * ((a >> 2) + 32'd1);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    // Memory controller model: answers each request after lat cycles, pauses while rdy is low.
    initial begin
        bit          busy;
        int          cnt;
        int          low_run;
        logic [31:0] cur;
        busy = 0; cnt = 0; low_run = 0; cur = '0;
        bus.mem_data_en = 1'b0;
        bus.mem_data    = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                busy = 0;
                low_run = 0;
                bus.mem_data_en = 1'b0;
            end else begin
                if (bus.mem_data_en) begin
                    bus.mem_data_en = 1'b0;
                    busy = 0;
                end else begin
                    if (!busy && bus.mem_req_en) begin
                        busy = 1;
                        cur = bus.mem_req_addr;
                        req_q.push_back(cur);
                        nreq++;
                        if (cur[3:2] != 2'b00) check("req_gap", low_run, 1);
                        low_run = 0;
                        cnt = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
                    end
                    if (busy && rdy) begin
                        if (cnt == 0) begin
                            bus.mem_data    = memval(cur);
                            bus.mem_data_en = 1'b1;
                            ndata++;
                        end else begin
                            cnt--;
                        end
                    end
                end
                if (!bus.mem_req_en && rdy) low_run++;
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (bus.icache_data_en === 1'b1) nresp++;
    end

    // mode 0: plain query, 1: flush after the second refill word, 2: rdy low for 3 cycles mid-refill
    task automatic run_query(input logic [31:0] pc, input int mode);
        logic        exp_hit;
        logic [31:0] base, frz_addr;
        int          r0, d0, q0, cyc;
        bit          got, flushed, froze;
        exp_hit = m_valid[pc[7:4]] && (m_tag[pc[7:4]] == pc[31:8]);
        base    = {pc[31:4], 4'h0};
        req_q.delete();
        r0 = nreq; d0 = ndata; q0 = nresp;
        got = 0; flushed = 0; froze = 0; cyc = 0;
        @(negedge clk);
        bus.icache_query_en = 1'b1;
        bus.icache_query_pc = pc;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (flush) begin
                flush = 1'b0;
            end else if (mode == 1 && !flushed && (ndata - d0) == 2 && !bus.mem_data_en) begin
                flush = 1'b1;
                bus.icache_query_en = 1'b0;
                flushed = 1;
            end
            if (mode == 2 && !froze && cyc >= 2 && bus.mem_req_en && !bus.mem_data_en) begin
                frz_addr = bus.mem_req_addr;
                rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("frz_req_en", {31'd0, bus.mem_req_en}, 32'd1);
                    check("frz_req_addr", bus.mem_req_addr, frz_addr);
                end
                rdy = 1'b1;
                froze = 1;
            end
            if (bus.icache_data_en) got = 1;
            if (mode == 1 && flushed && (ndata - d0) >= 4 && !bus.mem_data_en) break;
        end
        if (mode == 1) begin
            repeat (3) @(negedge clk);
            check("flush_words", ndata - d0, 4);
            check("flush_no_resp", nresp - q0, 0);
        end else begin
            check("resp_seen", {31'd0, got}, 32'd1);
            if (got) begin
                check("addr_comfirm", bus.icache_addr_comfirm, pc);
                check("data", bus.icache_data, memval(pc));
                if (exp_hit) check("hit_latency", cyc, 1);
                @(negedge clk);
                check("no_dup_pulse", {31'd0, bus.icache_data_en}, 32'd0);
                check("one_resp", nresp - q0, 1);
            end
            bus.icache_query_en = 1'b0;
        end
        check("req_count", nreq - r0, exp_hit ? 0 : 4);
        if (!exp_hit) begin
            for (int i = 0; i < 4; i++)
                if (req_q.size() > 0) check("req_addr", req_q.pop_front(), base + 32'(4 * i));
            m_valid[pc[7:4]] = 1;
            m_tag[pc[7:4]]   = pc[31:8];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int w;
        rst_n = 1'b0; rdy = 1'b1; flush = 1'b0;
        bus.icache_query_en = 1'b0;
        bus.icache_query_pc = '0;
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_tag[i] = '0; end
        repeat (3) @(negedge clk);
        check("rst_data_en", {31'd0, bus.icache_data_en}, 32'd0);
        check("rst_addr_comfirm", bus.icache_addr_comfirm, 32'd0);
        check("rst_data", bus.icache_data, 32'd0);
        check("rst_req_en", {31'd0, bus.mem_req_en}, 32'd0);
        check("rst_req_addr", bus.mem_req_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        lat_mode = 1;
        run_query(32'h0, 0);
        run_query(32'h8, 0);
        run_query(32'h100, 0);
        run_query(32'h0, 0);
        run_query(32'h40, 1);
        run_query(32'h44, 0);

        lat_mode = 8;
        run_query(32'h80, 2);

        lat_mode = -1;
        for (int n = 0; n < 30; n++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 2) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
            run_query(pc, 0);
        end

        lat_mode = 8;
        @(negedge clk);
        bus.icache_query_en = 1'b1;
        bus.icache_query_pc = 32'h000ABC00;
        w = 0;
        while (!bus.mem_req_en && w < 5) begin @(negedge clk); w++; end
        check("pre_rst_req_en", {31'd0, bus.mem_req_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_req_en", {31'd0, bus.mem_req_en}, 32'd0);
        check("async_rst_data_en", {31'd0, bus.icache_data_en}, 32'd0);
        check("async_rst_req_addr", bus.mem_req_addr, 32'd0);
        bus.icache_query_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) m_valid[i] = 0;
        lat_mode = 1;
        run_query(32'h44, 0);
        run_query(32'h48, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache; the responder for the instruction fetcher's ICache query interface.
- Serves one fetch query at a time.
  - Hit: one-cycle response.
  - Miss: refills a whole line from the memory controller with word-granular requests, then responds.
- Sits between Instruction_Fetcher and the memory controller/arbiter. Receives the RoB flush signal so it never answers a squashed query.

Parameters:
- INDEX_WIDTH, 4, log2 of line count (default 16 lines).
- OFFSET_WIDTH, 2, log2 of 32-bit words per line (default 4 words = 16 B).
- TAG_WIDTH, 32-INDEX_WIDTH-OFFSET_WIDTH-2, derived tag width.

Ports:
- clk_in  input  1  the single clock.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  high = run; low = hold all state and outputs.
- flush_signal  input  1  RoB mispredict flush; cancels any pending response.
- icache_query_en  input  1  fetcher query request; held high until a response is seen.
- icache_query_pc  input  32  fetch address, word aligned; stable while query_en is high.
- icache_data_en  output  1  one-cycle response pulse.
- icache_addr_comfirm  output  32  pc being answered; valid with data_en.
- icache_data  output  32  instruction word; valid with data_en.
- mem_req_en  output  1  word read request to the memory controller.
- mem_req_addr  output  32  word-aligned read address.
- mem_data_en  input  1  one-cycle pulse: mem_data valid for the current request.
- mem_data  input  32  returned word.

Behaviour:
- Reset (rst_in low, asynchronous):
  - All outputs 0.
  - All valid bits cleared, state IDLE, word counter 0, cooldown flag 0.
  - Tag and data arrays need not be cleared.
- rdy_in low: nothing changes, including flush handling. Flush is sampled only when rdy_in is high.
- Address split: offset = pc[OFFSET_WIDTH+1:2], index = pc[OFFSET_WIDTH+INDEX_WIDTH+1:OFFSET_WIDTH+2], tag = upper TAG_WIDTH bits.
- Cooldown: on the edge after any cycle in which icache_data_en was 1, query_en is ignored (the fetcher's deassertion is registered). This prevents a duplicate response.
- States:
  - IDLE.
    - If query_en && !cooldown && !flush: latch pc.
    - Hit (valid[index] && tag match): next edge sets data_en=1, addr_comfirm=pc, data=line word; stay IDLE with cooldown=1.
    - Miss: go REFILL with counter=0 and mem_req_en=1, mem_req_addr={pc[31:OFFSET_WIDTH+2], 0...}.
  - REFILL.
    - Hold mem_req_en/addr until mem_data_en.
    - On mem_data_en: write mem_data into data[index][counter] and drop mem_req_en for exactly one cycle.
    - Then re-raise it with addr+4 and counter+1. Counter wraps inside the line only; base = line start.
    - After word 2^OFFSET_WIDTH-1 is written: set tag and valid, go RESPOND.
  - RESPOND: data_en=1 with latched pc and word at its offset; go IDLE with cooldown=1.
- data_en is cleared on every edge where no response is produced (strict one-cycle pulse).
- flush_signal:
  - IDLE: no new query is accepted that cycle; a hit response scheduled for the same edge is suppressed.
  - REFILL: the refill completes and the line becomes valid. A "cancel" flag suppresses the final RESPOND and the cache returns to IDLE.
  - RESPOND: response suppressed.
- Memory side never aborts mid-request; at most one outstanding mem request.
- Simultaneous query_en and mem_data_en: only the REFILL path is relevant; no queries are accepted outside IDLE.
- Hit latency 1 cycle from query sample. Miss latency = sum of memory latencies + one idle cycle per word + 2.

Test Plan:
- Cold miss: after reset, query pc=0x0; memory returns 0x11,0x22,0x33,0x44 for addrs 0x0,0x4,0x8,0xC -> four requests in address order, each separated by one low cycle; single data_en with addr_comfirm=0x0, data=0x11.
- Hit after fill: query pc=0x8 -> no mem_req_en; data_en exactly one cycle after the query is sampled, data=0x33; query_en still high in the following cycle produces no second pulse.
- Conflict miss: query pc=0x100 (index 0, different tag) -> refill at 0x100..0x10C and response. Then query 0x0 -> miss again and refill.
- Flush during refill: query pc=0x40, assert flush_signal after the second word -> remaining words still requested, no data_en. A later query 0x44 hits in 1 cycle.
- rdy_in low for 3 cycles mid-refill with mem_data_en low -> mem_req_en/addr frozen; refill resumes unchanged.
- Async reset pulse during REFILL (no clock edge) -> mem_req_en and data_en drop immediately; a subsequent query to a previously valid line misses.
